// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue (package fetch_pkg).
// Entry layout is {pc, instr}. The queue stores it as a flat vector of the
// same layout so that its widths can follow the top-level parameters.
package fetch_pkg;

    localparam int FETCH_DEPTH  = 4;
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Value presented on decInstr while the queue is empty.
    localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: small synchronous FIFO with a synchronous clear.
// The head is read combinationally from a register array. This lets a word
// written on one edge be visible at the output right after that edge.
// clear has priority over push and pop, and drops all contents.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPop   = pop && (count != '0);
    assign doPush  = push && ((count != CW'(DEPTH)) || doPop);
    assign popData = mem[rdPtr];

    // Storage write; contents need no reset because count qualifies them.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy tracking, with a net update on simultaneous push and pop.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: issues in-order instruction fetches from the PC register.
// It tags each request with its PC and buffers returned words for decode.
// A redirect (flush) drops all queued work. Responses still in flight are
// counted down and discarded in the DRAIN state.
// Optional build macro FETCH_QUEUE_PERF_EN adds a 32-bit saturating counter,
// perfStarveCnt. It counts cycles where decode was ready but nothing was valid.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      pcAddr,
    output logic                   pcWriteEn,
    input  logic                   flush,
    output logic                   imemReqValid,
    input  logic                   imemReqReady,
    output logic [ADDR_W-1:0]      imemReqAddr,
    input  logic                   imemRspValid,
    input  logic [DATA_W-1:0]      imemRspData,
    output logic                   decValid,
    input  logic                   decReady,
    output logic [DATA_W-1:0]      decInstr,
    output logic [ADDR_W-1:0]      decPc,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]            perfStarveCnt,
`endif
    output logic [$clog2(DEPTH):0] queueCount
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t               state;
    logic [CW-1:0]              outstanding;
    logic [CW-1:0]              dropCnt;
    logic [CW-1:0]              rspRemain;
    logic [CW-1:0]              entryCount;
    logic [CW-1:0]              tagCountUnused;
    logic [ADDR_W-1:0]          tagHead;
    logic [ADDR_W+DATA_W-1:0]   entryHead;
    logic                       creditOk;
    logic                       reqFire;
    logic                       dropping;
    logic                       rspKeep;
    logic                       decFire;

    // Credit covers both words in flight and words already buffered.
    assign creditOk     = ({1'b0, outstanding} + {1'b0, entryCount}) < (CW+1)'(DEPTH);
    assign imemReqValid = reset && (state == RUN) && !flush && creditOk;
    assign imemReqAddr  = pcAddr;
    assign reqFire      = imemReqValid && imemReqReady;
    assign pcWriteEn    = reset && (flush || reqFire);

    assign dropping  = (dropCnt != '0);
    assign rspKeep   = imemRspValid && !dropping && !flush;
    assign rspRemain = outstanding - CW'(imemRspValid);

    assign decValid   = (entryCount != '0);
    assign decFire    = decValid && decReady;
    assign decInstr   = decValid ? entryHead[DATA_W-1:0] : DATA_W'(NOP_INSTR);
    assign decPc      = decValid ? entryHead[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign queueCount = entryCount;

    // PC tags of requests whose responses are still due, oldest first.
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) tagFifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (reqFire),
        .pushData (pcAddr),
        .pop      (rspKeep),
        .popData  (tagHead),
        .count    (tagCountUnused)
    );

    // Returned {pc, instr} entries waiting for decode.
    fetch_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) entryFifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (flush),
        .push     (rspKeep),
        .pushData ({tagHead, imemRspData}),
        .pop      (decFire),
        .popData  (entryHead),
        .count    (entryCount)
    );

    // Track in-flight requests and the discard countdown that follows a redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstanding + CW'(reqFire) - CW'(imemRspValid);
            if (flush && (state == RUN)) begin
                // Every response still owed belongs to the redirected stream.
                dropCnt <= rspRemain;
                state   <= (rspRemain != '0) ? DRAIN : RUN;
            end else if (imemRspValid && dropping) begin
                // In DRAIN, a repeated flush changes nothing: the count already covers all in flight.
                dropCnt <= dropCnt - 1'b1;
                if (dropCnt == CW'(1)) begin
                    state <= RUN;
                end
            end
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    // Count decode-starved cycles, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perfStarveCnt <= '0;
        end else if (decReady && !decValid && (perfStarveCnt != 32'hFFFF_FFFF)) begin
            perfStarveCnt <= perfStarveCnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch consumer of the PC register: reads the PC address, issues in-order requests to instruction memory and buffers returned words with their PC.
- Presents entries to decode through a valid/ready handshake.
- Produces the PC write-enable, so the PC advances exactly when a fetch is accepted or a redirect occurs.
- Sits between the PC register / next-PC mux and the IF/ID boundary.

Parameters:
- DEPTH, 4, queue entries and maximum in-flight plus buffered requests (power of 2, at least 2).
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pcAddr  in  ADDR_W  current PC from the PC register.
- pcWriteEn  out  1  PC load enable to the PC register.
- flush  in  1  redirect (branch/jump taken); the next-PC mux already selects the target.
- imemReqValid  out  1  fetch request valid.
- imemReqReady  in  1  memory accepts the request.
- imemReqAddr  out  ADDR_W  fetch address.
- imemRspValid  in  1  response word valid; responses arrive in order, any latency of at least 1 cycle, no backpressure.
- imemRspData  in  DATA_W  instruction word.
- decValid  out  1  head entry valid.
- decReady  in  1  decode accepts the head entry.
- decInstr  out  DATA_W  head instruction.
- decPc  out  ADDR_W  head PC.
- queueCount  out  $clog2(DEPTH)+1  buffered entry count.

Behaviour:
- Reset, sampled on posedge clk while reset==0:
  - Queue emptied; outstanding=0; dropCnt=0; state=RUN.
  - All outputs 0: pcWriteEn, imemReqValid, decValid, queueCount, decInstr, decPc.
- Credit rule: imemReqValid=1 only when state==RUN, flush==0, and outstanding+queueCount < DEPTH.
- Request address: imemReqAddr=pcAddr (combinational).
  - The PC tag is pushed into a DEPTH-deep tag FIFO on each request handshake.
- pcWriteEn = flush | (imemReqValid & imemReqReady), combinational.
  - The PC moves once per accepted request, or loads the redirect target on flush.
  - Never asserted while stalled.
- Response handling:
  - If dropCnt>0: the response is discarded and dropCnt decrements.
  - Otherwise the word is written with the popped tag as {pc,instr}.
  - outstanding decrements on every response.
- Decode handshake:
  - Head popped when decValid & decReady.
  - decInstr/decPc are held stable while decValid=1 & decReady=0.
  - Response-to-decValid latency: 1 cycle (registered write, FIFO head visible the next cycle).
- Simultaneous push, pop and request in one cycle are all legal; counts update net.
- Full queue (queueCount==DEPTH): no requests issued; a response cannot arrive because of the credit rule.
- Flush:
  - Same cycle: queue and tag FIFO cleared; dropCnt <= outstanding minus any response consumed that cycle.
  - State goes to DRAIN if that result is >0, else stays RUN.
  - No request is issued during the flush cycle.
- FSM:
  - RUN -> DRAIN on flush with pending responses.
  - DRAIN -> RUN when dropCnt reaches 0 (last discard).
  - In DRAIN, flush again leaves dropCnt unchanged (already counting all in flight).
- Reset mid-operation: in-flight memory responses after reset are the memory's responsibility; the memory is reset by the same reset.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- Defined: adds output perfStarveCnt (32-bit), incremented each cycle decReady==1 & decValid==0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset only.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - FETCH_DEPTH default.
  - fetch_entry_t struct {pc, instr}.
  - fetch_state_t enum {RUN, DRAIN}.
  - NOP_INSTR constant (all-zero) for debug fill.
- Sub-module fetch_fifo:
  - Parameterised sync FIFO (data, DEPTH) with clear input.
  - Instantiated twice: tag FIFO and entry queue.

Test Plan:
- Steady stream: reset release, pcAddr 0,4,8,…; imemReqReady=1; response latency 2 -> pcWriteEn pulses each cycle until 4 in flight with decReady=0; decPc 0,4,8,12 in order once decReady=1.
- Backpressure: decReady=0 for 10 cycles -> exactly DEPTH=4 requests issued, pcWriteEn low afterwards; decInstr/decPc stable; queueCount=4.
- Flush with 3 outstanding: flush pulse, pcAddr=0x100 the next cycle -> pcWriteEn=1 during the flush cycle; the next 3 responses discarded; first decPc after flush = 0x100; no request until DRAIN exits.
- Memory stall: imemReqReady=0 for 5 cycles -> imemReqValid held 1, imemReqAddr stable, pcWriteEn=0 throughout.
- Reset mid-stream: reset=0 for one cycle with queueCount=3 -> next cycle all outputs 0, queueCount=0, state=RUN.
- PERF (macro defined): decReady=1 with an empty queue for 7 cycles after reset -> perfStarveCnt=7.
